// File: rtl/spi_shift_reg_gen.sv
// SPI data shift register: select-gated parallel load, framed serial shift, double-buffered RX with overrun flag.
// Latency: DO/POUT update at the edge of each accepted shift tick; RXDATA/RXVALID/READY appear the cycle after the final tick.
// Backpressure: none; an unread RXDATA is overwritten by the next frame and OVR records the loss.
module spi_shift_reg_gen #(
    parameter int                WIDTH     = 8,
    parameter int                CNT_W     = 4,
    parameter int                RSEL_W    = 2,
    parameter logic [RSEL_W-1:0] ID        = 2'b01,
    parameter int                LSB_FIRST = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [RSEL_W-1:0] RSELIN,
    input  logic              PLDEN,
    input  logic [WIDTH-1:0]  PLD,
    input  logic              START,
    input  logic              SHIFT_EN,
    input  logic              DI,
    output logic              DO,
    output logic [WIDTH-1:0]  POUT,
    output logic [WIDTH-1:0]  RXDATA,
    output logic              RXVALID,
    input  logic              RXACK,
    output logic              OVR,
    input  logic              OVRCLR,
    output logic              BUSY,
    output logic              READY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter value seen on the last bit of a frame.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   pout_q, pout_d;
    logic [WIDTH-1:0]   rxdata_q, rxdata_d;
    logic               do_q, do_d;
    logic               rxvalid_q, rxvalid_d;
    logic               ovr_q, ovr_d;

    logic               sel;
    logic [WIDTH-1:0]   shifted;
    logic               out_bit;
    logic               capture;

    assign sel = (RSELIN == ID);

    // Shift-direction datapath: next register image and the bit leaving it.
    always_comb begin
        shifted = pout_q;
        out_bit = 1'b0;
        if (LSB_FIRST != 0) begin
            shifted = {DI, pout_q[WIDTH-1:1]};
            out_bit = pout_q[0];
        end else begin
            shifted = {pout_q[WIDTH-2:0], DI};
            out_bit = pout_q[WIDTH-1];
        end
    end

    // Next-state and datapath control for the IDLE -> SHIFT -> DONE frame sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pout_d   = pout_q;
        do_d     = do_q;
        rxdata_d = rxdata_q;
        capture  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Load and start in the same cycle: the first shift then acts on PLD.
                if (sel && PLDEN) begin
                    pout_d = PLD;
                end
                if (sel && START) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (SHIFT_EN) begin
                    do_d   = out_bit;
                    pout_d = shifted;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        capture  = 1'b1;
                        rxdata_d = shifted;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Receive handshake and overrun: a capture always wins over a clear in the same cycle.
    always_comb begin
        rxvalid_d = rxvalid_q;
        ovr_d     = ovr_q;
        if (RXACK) begin
            rxvalid_d = 1'b0;
        end
        if (OVRCLR) begin
            ovr_d = 1'b0;
        end
        if (capture) begin
            rxvalid_d = 1'b1;
            if (rxvalid_q && !RXACK) begin
                ovr_d = 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pout_q    <= '0;
            rxdata_q  <= '0;
            do_q      <= 1'b0;
            rxvalid_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pout_q    <= pout_d;
            rxdata_q  <= rxdata_d;
            do_q      <= do_d;
            rxvalid_q <= rxvalid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign DO      = do_q;
    assign POUT    = pout_q;
    assign RXDATA  = rxdata_q;
    assign RXVALID = rxvalid_q;
    assign OVR     = ovr_q;
    assign BUSY    = (state_q != ST_IDLE);
    assign READY   = (state_q == ST_DONE);

endmodule

// File: tb/tb_spi_shift_reg_gen.sv
// Bench for spi_shift_reg_gen: MSB-first and LSB-first instances driven by the same inputs.
// A frame-level model tracks both; outputs are compared every negedge, plus literal expectations.
// Directed scenarios first, then randomized traffic.
module tb_spi_shift_reg_gen;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic [1:0] rsel = 2'b00;
    logic       plden = 1'b0;
    logic [7:0] pld = 8'h00;
    logic       start = 1'b0;
    logic       shift_en = 1'b0;
    logic       di = 1'b0;
    logic       rxack = 1'b0;
    logic       ovrclr = 1'b0;

    logic [1:0] d_do, d_rxv, d_ovr, d_busy, d_ready;
    logic [7:0] d_pout [2];
    logic [7:0] d_rx   [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    spi_shift_reg_gen #(.WIDTH(8), .CNT_W(4), .RSEL_W(2), .ID(2'b01), .LSB_FIRST(0)) dut_m (
        .CLK(clk), .RST(rst), .RSELIN(rsel), .PLDEN(plden), .PLD(pld), .START(start),
        .SHIFT_EN(shift_en), .DI(di), .DO(d_do[0]), .POUT(d_pout[0]), .RXDATA(d_rx[0]),
        .RXVALID(d_rxv[0]), .RXACK(rxack), .OVR(d_ovr[0]), .OVRCLR(ovrclr),
        .BUSY(d_busy[0]), .READY(d_ready[0])
    );

    spi_shift_reg_gen #(.WIDTH(8), .CNT_W(4), .RSEL_W(2), .ID(2'b01), .LSB_FIRST(1)) dut_l (
        .CLK(clk), .RST(rst), .RSELIN(rsel), .PLDEN(plden), .PLD(pld), .START(start),
        .SHIFT_EN(shift_en), .DI(di), .DO(d_do[1]), .POUT(d_pout[1]), .RXDATA(d_rx[1]),
        .RXVALID(d_rxv[1]), .RXACK(rxack), .OVR(d_ovr[1]), .OVRCLR(ovrclr),
        .BUSY(d_busy[1]), .READY(d_ready[1])
    );

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 in frame, 2 frame just completed. nbits: bits shifted so far.
    int         m_phase [2];
    int         m_nbits [2];
    logic [7:0] m_pout  [2];
    logic [7:0] m_rx    [2];
    logic       m_do    [2];
    logic       m_rxv   [2];
    logic       m_ovr   [2];

    task automatic model_step(input int m);
        int   pv;
        int   nv;
        logic ob;
        bit   cap;
        bit   old_rxv;
        pv      = int'(m_pout[m]);
        old_rxv = m_rxv[m];
        cap     = 1'b0;
        if (rst) begin
            m_phase[m] = 0; m_nbits[m] = 0; m_pout[m] = 8'h00; m_rx[m] = 8'h00;
            m_do[m] = 1'b0; m_rxv[m] = 1'b0; m_ovr[m] = 1'b0;
            return;
        end
        if (m == 0) begin
            nv = (pv * 2 + int'(di)) % 256;
            ob = (pv >= 128);
        end else begin
            nv = pv / 2 + int'(di) * 128;
            ob = ((pv % 2) == 1);
        end
        case (m_phase[m])
            0: begin
                if (rsel == 2'b01 && plden) m_pout[m] = pld;
                if (rsel == 2'b01 && start) begin
                    m_phase[m] = 1;
                    m_nbits[m] = 0;
                end
            end
            1: begin
                if (shift_en) begin
                    m_do[m]    = ob;
                    m_pout[m]  = 8'(nv);
                    m_nbits[m] = m_nbits[m] + 1;
                    if (m_nbits[m] == 8) begin
                        cap        = 1'b1;
                        m_phase[m] = 2;
                    end
                end
            end
            default: m_phase[m] = 0;
        endcase
        if (cap) begin
            m_rx[m]  = 8'(nv);
            m_rxv[m] = 1'b1;
            if (old_rxv && !rxack) m_ovr[m] = 1'b1;
            else if (ovrclr) m_ovr[m] = 1'b0;
        end else begin
            if (rxack) m_rxv[m] = 1'b0;
            if (ovrclr) m_ovr[m] = 1'b0;
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_phase[m] = 0; m_nbits[m] = 0; m_pout[m] = 8'h00; m_rx[m] = 8'h00;
            m_do[m] = 1'b0; m_rxv[m] = 1'b0; m_ovr[m] = 1'b0;
        end
    end

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                check(m == 0 ? "model_msb" : "model_lsb",
                      {11'd0, d_do[m], d_pout[m], d_rx[m], d_rxv[m], d_ovr[m], d_busy[m], d_ready[m]},
                      {11'd0, m_do[m], m_pout[m], m_rx[m], m_rxv[m], m_ovr[m],
                       (m_phase[m] != 0), (m_phase[m] == 2)});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        plden = 1'b0; start = 1'b0; shift_en = 1'b0; rxack = 1'b0; ovrclr = 1'b0; rst = 1'b0;
    endtask

    // Load p, start, shift dbyte in MSB-first with gap idle cycles before each tick.
    task automatic frame(input logic [7:0] p, input logic [7:0] dbyte, input int gap,
                         input bit ack_last, input bit noisy);
        quiet();
        rsel = 2'b01; plden = 1'b1; pld = p;
        cyc();
        plden = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        check("busy_after_start", {30'd0, d_busy}, 32'd3);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gap; g++) begin
                shift_en = 1'b0;
                cyc();
            end
            shift_en = 1'b1;
            di = dbyte[7-i];
            rxack = ack_last && (i == 7);
            if (noisy) begin
                start = 1'b1; plden = 1'b1; pld = 8'h00;
            end
            cyc();
            quiet();
            check("do_seq", {31'd0, d_do[0]}, {31'd0, p[7-i]});
            if (i < 7) check("ready_early", {30'd0, d_ready}, 32'd0);
        end
        check("ready_pulse", {30'd0, d_ready}, 32'd3);
        check("busy_done", {30'd0, d_busy}, 32'd3);
        check("rxdata_msb", {24'd0, d_rx[0]}, {24'd0, dbyte});
        check("rxvalid_set", {30'd0, d_rxv}, 32'd3);
        cyc();
        check("ready_drop", {30'd0, d_ready}, 32'd0);
        check("busy_drop", {30'd0, d_busy}, 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Reset with random inputs on the other pins.
        rsel = 2'($urandom % 4); plden = 1'($urandom % 2); pld = 8'($urandom);
        start = 1'($urandom % 2); shift_en = 1'($urandom % 2); di = 1'($urandom % 2);
        rxack = 1'($urandom % 2); ovrclr = 1'($urandom % 2);
        rst = 1'b1;
        cyc();
        quiet();
        chk_en = 1'b1;
        check("rst_pout", {24'd0, d_pout[0]}, 32'd0);
        check("rst_rxdata", {24'd0, d_rx[0]}, 32'd0);
        check("rst_flags", {22'd0, d_do, d_rxv, d_ovr, d_busy, d_ready}, 32'd0);

        // MSB-first frame: PLD=0xA5, DI=0x3C.
        frame(8'hA5, 8'h3C, 0, 1'b0, 1'b0);
        check("lsb_rx_3c", {24'd0, d_rx[1]}, 32'h3C);

        // Same frame with ticks every third cycle; acknowledge first.
        rxack = 1'b1; cyc(); quiet();
        check("ack_clears", {30'd0, d_rxv}, 32'd0);
        frame(8'hA5, 8'h3C, 2, 1'b0, 1'b0);
        check("gap_pout", {24'd0, d_pout[0]}, 32'h3C);

        // Select mismatch: load and start ignored.
        rsel = 2'b10; plden = 1'b1; pld = 8'hFF; start = 1'b1;
        cyc(); quiet();
        check("nosel_pout", {24'd0, d_pout[0]}, 32'h3C);
        check("nosel_busy", {30'd0, d_busy}, 32'd0);

        // START/PLDEN pulses during SHIFT have no effect.
        rxack = 1'b1; cyc(); quiet();
        frame(8'h5A, 8'hC3, 1, 1'b0, 1'b1);

        // Overrun: two frames with no acknowledge, then clear.
        rxack = 1'b1; ovrclr = 1'b1; cyc(); quiet();
        frame(8'h00, 8'h11, 0, 1'b0, 1'b0);
        frame(8'h00, 8'h22, 0, 1'b0, 1'b0);
        check("ovr_set", {30'd0, d_ovr}, 32'd3);
        check("ovr_rx", {24'd0, d_rx[0]}, 32'h22);
        ovrclr = 1'b1; cyc(); quiet();
        check("ovr_clr", {30'd0, d_ovr}, 32'd0);

        // Acknowledge on the second capture cycle: no overrun.
        rxack = 1'b1; cyc(); quiet();
        frame(8'h00, 8'h11, 0, 1'b0, 1'b0);
        frame(8'h00, 8'h22, 0, 1'b1, 1'b0);
        check("ack_race_ovr", {30'd0, d_ovr}, 32'd0);
        check("ack_race_vld", {30'd0, d_rxv}, 32'd3);

        // LSB-first with mid-frame reset.
        rsel = 2'b01; pld = 8'h01; plden = 1'b1; start = 1'b1;
        cyc(); quiet();
        shift_en = 1'b1; di = 1'b0;
        cyc();
        check("lsb_first_do", {31'd0, d_do[1]}, 32'd1);
        cyc(); cyc(); quiet();
        rst = 1'b1; cyc(); quiet();
        check("midrst_pout", {24'd0, d_pout[1]}, 32'd0);
        check("midrst_busy", {30'd0, d_busy}, 32'd0);
        frame(8'h96, 8'h5A, 0, 1'b0, 1'b0);
        check("lsb_after_rst_rx", {24'd0, d_rx[1]}, 32'h5A);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst      = (($urandom % 300) == 0);
            rsel     = ($urandom % 2) ? 2'b01 : 2'($urandom % 4);
            plden    = (($urandom % 4) == 0);
            pld      = 8'($urandom);
            start    = (($urandom % 5) == 0);
            shift_en = (($urandom % 2) == 0);
            di       = 1'($urandom % 2);
            rxack    = (($urandom % 8) == 0);
            ovrclr   = (($urandom % 12) == 0);
            cyc();
        end
        quiet();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_shift_reg_gen.md
Name: spi_shift_reg_gen

Overview:
- Parametrised SPI data shift register.
- Adds to the basic 8-bit select-gated shift/parallel-load register:
  - configurable width and bit order;
  - frame control with a bit counter;
  - double-buffered receive holding register with valid/ack handshake;
  - sticky overrun flag.
- Sits between the 8051 SFR bus (register select, parallel load, RX readout) and the SPI bit engine, which supplies the shift tick and DI.

Parameters:
- WIDTH, 8: frame and shift-register width in bits (>=2).
- CNT_W, 4: bit-counter width; must satisfy 2**CNT_W > WIDTH-1.
- RSEL_W, 2: register-select width.
- ID, 2'b01: select code that enables this instance.
- LSB_FIRST, 0: 0 = MSB shifted out first; 1 = LSB shifted out first.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- RSELIN  in  RSEL_W  register select; the instance is selected when RSELIN == ID.
- PLDEN  in  1  parallel-load strobe; honoured only when selected and in IDLE.
- PLD  in  WIDTH  parallel-load data.
- START  in  1  frame start; honoured only when selected and in IDLE.
- SHIFT_EN  in  1  one-cycle shift tick from the bit engine; ignored outside SHIFT.
- DI  in  1  serial input.
- DO  out  1  registered serial output.
- POUT  out  WIDTH  live shift-register contents, bit WIDTH-1 = MSB.
- RXDATA  out  WIDTH  completed-frame holding register.
- RXVALID  out  1  RXDATA holds unread data.
- RXACK  in  1  consumer read strobe; clears RXVALID.
- OVR  out  1  sticky overrun flag.
- OVRCLR  in  1  clears OVR.
- BUSY  out  1  high when state != IDLE.
- READY  out  1  one-cycle frame-complete pulse (high in DONE).

Behaviour:
- Reset (RST=1 at an edge; overrides everything, including mid-frame):
  - state = IDLE; bit counter = 0.
  - POUT, RXDATA, DO, RXVALID, OVR = 0.
  - BUSY and READY are decoded from state, so both are 0.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - sel & PLDEN: POUT <= PLD.
  - sel & START: state <= SHIFT, counter <= 0.
  - PLDEN and START in the same cycle: the load takes effect and SHIFT is entered at the same edge, so the first shift acts on PLD.
- SHIFT, on each cycle with SHIFT_EN=1:
  - LSB_FIRST=0: DO <= POUT[WIDTH-1]; POUT <= {POUT[WIDTH-2:0], DI}.
  - LSB_FIRST=1: DO <= POUT[0]; POUT <= {DI, POUT[WIDTH-1:1]}.
  - counter increments.
  - Cycles with SHIFT_EN=0 hold all state, so gap length does not matter.
  - PLDEN and START are ignored in SHIFT and DONE.
- Final shift (counter == WIDTH-1 with SHIFT_EN=1), at the same edge:
  - POUT takes the shifted value.
  - RXDATA <= the same shifted value.
  - RXVALID <= 1.
  - state <= DONE.
- Overrun check at the final-shift edge:
  - If RXVALID=1 and RXACK=0, then OVR <= 1 and RXDATA is overwritten with the new frame.
  - If RXACK=1 in that same cycle, there is no overrun and RXVALID stays 1 (set wins).
- DONE: lasts exactly one cycle with READY=1 and BUSY=1; the next state is always IDLE. DO holds its last value.
- RXACK=1 with no concurrent capture: RXVALID <= 0 and RXDATA holds.
- OVRCLR: OVR <= 0; if an overrun set occurs in the same cycle, set wins.
- Latency:
  - START accepted at edge n: BUSY is high from cycle n+1.
  - RXVALID and READY are high in the cycle after the WIDTH-th SHIFT_EN.
  - BUSY falls one cycle after READY.
- Widths: counter compares against WIDTH-1 zero-extended to CNT_W; no wrap occurs within a frame.

Test Plan:
- Reset: RST=1 for one cycle with random inputs -> POUT=RXDATA=0x00; DO, RXVALID, OVR, BUSY, READY all 0.
- MSB-first frame (WIDTH=8, ID=01): RSELIN=01, PLD=0xA5 with PLDEN, then START; SHIFT_EN every cycle; DI drives 0x3C MSB-first -> DO sequence 1,0,1,0,0,1,0,1; after the 8th tick RXDATA=0x3C, RXVALID=1, READY high for exactly one cycle; BUSY low one cycle later.
- Gapped ticks: repeat the previous scenario with SHIFT_EN every 3rd cycle -> identical DO, RXDATA, POUT; READY follows the 8th tick, not a cycle count.
- Select mismatch: RSELIN=10, PLDEN with PLD=0xFF, plus START -> POUT unchanged, BUSY stays 0; a START pulse during SHIFT -> no effect on counter or state.
- Overrun:
  - Two frames (0x11 then 0x22) with no RXACK -> OVR=1, RXDATA=0x22; OVRCLR -> OVR=0.
  - Repeat with RXACK asserted on the second capture cycle -> OVR stays 0, RXVALID=1.
- LSB_FIRST=1 with mid-frame reset: PLD=0x01, START -> first DO bit = 1; RST after 3 ticks -> state IDLE, POUT=0x00, BUSY=0; a new START then completes a full 8-tick frame normally.
